// File: rtl/instr_loader.sv
// instr_loader: receives a length-prefixed byte stream from a host, writes the instructions into instruction memory, then starts the processor
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   in_data/in_valid      host byte stream (valid/ready handshake)
//   in_ready              loader can take a byte this cycle
//   wr_en/wr_addr/wr_data instruction memory write port, one strobe per instruction
//   start                 one-cycle pulse once the whole program is written
//   busy                  a load is in progress
//   err                   sticky framing error, cleared only by reset
module instr_loader #(
   parameter int D = 12,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         wr_en,
   output logic [D-1:0] wr_addr,
   output logic [W-1:0] wr_data,
   output logic         start,
   output logic         busy,
   output logic         err
);
   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_INS_LO,
      S_INS_HI,
      S_FLUSH,
      S_START,
      S_ERR
   } state_t;
   state_t       state_q, state_d;
   logic [7:0]   len_lo_q, len_lo_d;
   logic [11:0]  n_q, n_d;
   logic [11:0]  cnt_q, cnt_d;
   logic [7:0]   lo_q, lo_d;
   logic         wr_en_q, wr_en_d;
   logic [D-1:0] wr_addr_q, wr_addr_d;
   logic [W-1:0] wr_data_q, wr_data_d;
   logic         xfer;
   logic [11:0]  n_new;
   assign in_ready = state_q inside {S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI};
   assign xfer     = in_valid && in_ready;
   assign n_new    = {in_data[3:0], len_lo_q};
   assign busy     = state_q inside {S_LEN_HI, S_INS_LO, S_INS_HI, S_FLUSH, S_START};
   assign start    = state_q == S_START;
   assign err      = state_q == S_ERR;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   // The write is registered, so it lands in the cycle after the high byte; the last
   // one overlaps S_FLUSH, which is why start trails the final write by one cycle.
   always_comb begin
      state_d   = state_q;
      len_lo_d  = len_lo_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         S_LEN_LO: if (xfer) begin
            len_lo_d = in_data;
            state_d  = S_LEN_HI;
         end
         S_LEN_HI: if (xfer) begin
            n_d     = n_new;
            cnt_d   = '0;
            state_d = (in_data[7:4] != 4'h0) ? S_ERR : (n_new == 12'd0) ? S_START : S_INS_LO;
         end
         S_INS_LO: if (xfer) begin
            lo_d    = in_data;
            state_d = S_INS_HI;
         end
         S_INS_HI: if (xfer) begin
            if (in_data[7:1] != 7'd0) begin
               state_d = S_ERR;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = D'(cnt_q);
               wr_data_d = W'({in_data[0], lo_q});
               cnt_d     = cnt_q + 12'd1;
               state_d   = (cnt_q + 12'd1 == n_q) ? S_FLUSH : S_INS_LO;
            end
         end
         S_FLUSH: state_d = S_START;
         S_START: state_d = S_LEN_LO;
         default: state_d = state_q;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_LEN_LO;
         len_lo_q  <= '0;
         n_q       <= '0;
         cnt_q     <= '0;
         lo_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         len_lo_q  <= len_lo_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         lo_q      <= lo_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench for instr_loader against a stream-level reference model
module tb_instr_loader;
   localparam int D = 12;
   localparam int W = 9;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   in_data = 8'h00;
   logic         in_valid = 1'b0;
   logic         in_ready, wr_en, start, busy, err;
   logic [D-1:0] wr_addr;
   logic [W-1:0] wr_data;
   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int both = 0;
   typedef struct {int c; int a; int d;} wr_t;
   typedef struct {int a; int d; int bi;} ew_t;
   wr_t        wq[$];
   int         sq[$];
   bit         busy_log[int];
   logic [7:0] stream[$];
   ew_t        ew[$];
   int         es_bi[$];
   int         es_off[$];
   int         eb_bi[$];
   int         nacc;
   bit         eerr;

   instr_loader #(.D(D), .W(W)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      wr_t w;
      busy_log[cyc] = busy;
      if (wr_en) begin
         w.c = cyc;
         w.a = int'(wr_addr);
         w.d = int'(wr_data);
         wq.push_back(w);
      end
      if (start) sq.push_back(cyc);
      if (wr_en && start) both++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Walks the byte stream by the framing rules: expected writes, start points, error
   // position and how many bytes the loader should accept. Byte indices are mapped to
   // transfer cycles after the stream has been driven.
   function automatic void model();
      int i = 0;
      int n;
      logic [7:0] lo, hi;
      ew_t e;
      ew.delete(); es_bi.delete(); es_off.delete(); eb_bi.delete();
      eerr = 1'b0;
      nacc = 0;
      while (!eerr && i + 1 < stream.size()) begin
         n = int'(stream[i + 1][3:0]) * 256 + int'(stream[i]);
         nacc = i + 2;
         if (stream[i + 1][7:4] != 4'h0) eerr = 1'b1;
         for (int k = 0; k < n && !eerr; k++) begin
            lo = stream[i + 2 + 2 * k];
            hi = stream[i + 3 + 2 * k];
            nacc = i + 4 + 2 * k;
            if (hi > 8'd1) eerr = 1'b1;
            else begin
               e.a = k;
               e.d = int'(hi) * 256 + int'(lo);
               e.bi = i + 3 + 2 * k;
               ew.push_back(e);
            end
         end
         if (!eerr) begin
            es_bi.push_back(n == 0 ? i + 1 : i + 1 + 2 * n);
            es_off.push_back(n == 0 ? 0 : 1);
            eb_bi.push_back(i);
         end
         i += 2 + 2 * n;
      end
   endfunction

   function automatic int stall_of(int mode);
      return mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(3, 0));
   endfunction

   task automatic send(input logic [7:0] b, input int stall, output int e, output bit ok);
      repeat (stall) begin
         in_valid = 1'b0;
         in_data = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data = b;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         ok = in_ready;
         @(posedge clk); #1;
      end
      e = cyc;
      in_valid = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic run_stream(input string name, input int mode);
      int edges[$];
      int e, bad, sc;
      bit ok;
      model();
      wq.delete(); sq.delete();
      both = 0;
      for (int i = 0; i < nacc; i++) begin
         send(stream[i], stall_of(mode), e, ok);
         edges.push_back(e);
         n_cmp++;
         if (!ok) begin
            n_fail++;
            $display("FAIL %s accept[%0d]: got in_ready=0 for 20 cycles, want byte accepted", name, i);
         end
      end
      if (eerr) begin
         bad = 0;
         in_valid = 1'b1;
         repeat (6) begin
            in_data = 8'($urandom);
            if (in_ready !== 1'b0 || err !== 1'b1) bad++;
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         n_cmp++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL %s err_hold: got %0d cycles with in_ready=1 or err=0, want 0", name, bad);
         end
      end else begin
         repeat (4) begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (err !== eerr) begin
         n_fail++;
         $display("FAIL %s err: got %b want %b", name, err, eerr);
      end
      n_cmp++;
      if (wq.size() != ew.size()) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d want %0d", name, wq.size(), ew.size());
      end
      for (int k = 0; k < wq.size() && k < ew.size(); k++) begin
         n_cmp++;
         if (wq[k].c != edges[ew[k].bi] || wq[k].a != ew[k].a || wq[k].d != ew[k].d) begin
            n_fail++;
            $display("FAIL %s write[%0d]: got cyc=%0d addr=%0d data=%03h want cyc=%0d addr=%0d data=%03h",
                     name, k, wq[k].c, wq[k].a, wq[k].d, edges[ew[k].bi], ew[k].a, ew[k].d);
         end
      end
      n_cmp++;
      if (sq.size() != es_bi.size()) begin
         n_fail++;
         $display("FAIL %s start_count: got %0d want %0d", name, sq.size(), es_bi.size());
      end
      for (int j = 0; j < es_bi.size(); j++) begin
         sc = edges[es_bi[j]] + es_off[j];
         if (j < sq.size()) begin
            n_cmp++;
            if (sq[j] != sc) begin
               n_fail++;
               $display("FAIL %s start[%0d]: got cyc=%0d want cyc=%0d", name, j, sq[j], sc);
            end
         end
         bad = 0;
         for (int c = edges[eb_bi[j]]; c <= sc; c++) if (busy_log[c] !== 1'b1) bad++;
         if (busy_log[sc + 1] !== 1'b0) bad++;
         n_cmp++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL %s busy[%0d]: got %0d wrong cycles in %0d..%0d, want 0", name, j, bad, edges[eb_bi[j]], sc + 1);
         end
      end
      n_cmp++;
      if (both != 0) begin
         n_fail++;
         $display("FAIL %s start_with_wr_en: got %0d overlapping cycles want 0", name, both);
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_data = 8'hA5;
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      n_cmp++;
      if ({wr_en, start, busy, err, in_ready} !== 5'b00001 || wr_addr !== '0 || wr_data !== '0) begin
         n_fail++;
         $display("FAIL reset_vals: got wr_en=%b start=%b busy=%b err=%b in_ready=%b addr=%0h data=%0h want 0,0,0,0,1,0,0",
                  wr_en, start, busy, err, in_ready, wr_addr, wr_data);
      end
      in_valid = 1'b0;
      reset = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b want 1", in_ready);
      end
   endtask

   task automatic test_basic();
      do_reset();
      stream = {8'h03, 8'h00, 8'h12, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00};
      run_stream("basic", 0);
   endtask

   task automatic test_empty();
      do_reset();
      stream = {8'h00, 8'h00};
      run_stream("empty", 0);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL empty_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_hi_err();
      do_reset();
      stream = {8'h01, 8'h00, 8'hAA, 8'h02};
      run_stream("hi_err", 0);
   endtask

   task automatic test_len_err();
      do_reset();
      stream = {8'h00, 8'h10};
      run_stream("len_err", 2);
   endtask

   task automatic test_stall();
      do_reset();
      stream = {8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01};
      run_stream("stall", 1);
   endtask

   task automatic test_mid_reset();
      int e;
      bit ok;
      do_reset();
      send(8'h02, 0, e, ok);
      send(8'h00, 0, e, ok);
      send(8'h11, 0, e, ok);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy: got %b want 1", busy);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || wr_en !== 1'b0 || start !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_async: got busy=%b in_ready=%b wr_en=%b start=%b want 0,1,0,0", busy, in_ready, wr_en, start);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      wq.delete(); sq.delete();
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (wq.size() != 0 || sq.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: got %0d writes %0d starts want 0 0", wq.size(), sq.size());
      end
      stream = {8'h01, 8'h00, 8'h05, 8'h00};
      run_stream("after_reset", 0);
      do_reset();
      send(8'h02, 0, e, ok);
      send(8'h00, 0, e, ok);
      send(8'h11, 0, e, ok);
      send(8'h00, 0, e, ok);
      n_cmp++;
      if (wr_en !== 1'b1 || wr_data !== 9'h011 || wr_addr !== '0) begin
         n_fail++;
         $display("FAIL pre_reset_write: got wr_en=%b addr=%0h data=%03h want 1,0,011", wr_en, wr_addr, wr_data);
      end
      #2 reset = 1'b1;
      #1;
      wq.delete(); sq.delete();
      n_cmp++;
      if (wr_en !== 1'b0 || wr_data !== '0 || wr_addr !== '0) begin
         n_fail++;
         $display("FAIL write_reset_async: got wr_en=%b addr=%0h data=%03h want 0,0,000", wr_en, wr_addr, wr_data);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      n_cmp++;
      if (wq.size() != 0 || sq.size() != 0) begin
         n_fail++;
         $display("FAIL abort_quiet: got %0d writes %0d starts want 0 0", wq.size(), sq.size());
      end
   endtask

   task automatic test_big();
      do_reset();
      stream.delete();
      stream.push_back(8'h05);
      stream.push_back(8'h01);
      for (int k = 0; k < 261; k++) begin
         stream.push_back(8'($urandom));
         stream.push_back(8'($urandom_range(1, 0)));
      end
      run_stream("big", 0);
   endtask

   task automatic test_random();
      int loads, n, bad_k;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         stream.delete();
         loads = int'($urandom_range(3, 1));
         for (int l = 0; l < loads; l++) begin
            bad_k = -1;
            n = (l == 0 && it == 1) ? 0 : int'($urandom_range(6, 0));
            if (it >= 4 && l == loads - 1) begin
               n = int'($urandom_range(4, 1));
               bad_k = int'($urandom_range(n - 1, 0));
            end
            stream.push_back(8'(n));
            stream.push_back(8'(n >> 8));
            for (int k = 0; k < n; k++) begin
               stream.push_back(8'($urandom));
               stream.push_back(k == bad_k ? 8'($urandom_range(255, 2)) : 8'($urandom_range(1, 0)));
            end
         end
         run_stream($sformatf("rand%0d", it), it % 3);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_hi_err();
      test_stall();
      test_mid_reset();
      test_len_err();
      test_big();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter D, default 12, instruction address width; matches program counter width.
REQ-002 Parameter W, default 9, machine code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  byte stream from host.
REQ-006 in_valid  input  1  in_data holds a valid byte.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both 1 at a rising edge.
REQ-008 wr_en  output  1  instruction memory write strobe, one cycle per instruction.
REQ-009 wr_addr  output  D  instruction memory write address.
REQ-010 wr_data  output  W  machine code to write.
REQ-011 start  output  1  one-cycle pulse to the processor after the load completes.
REQ-012 busy  output  1  a load is in progress (header or body bytes accepted, start not yet pulsed).
REQ-013 err  output  1  sticky framing error flag.

Function
REQ-014 Stream format: LEN_LO byte, LEN_HI byte, then N instructions of two bytes each (low byte, then high byte); N = {LEN_HI[3:0], LEN_LO}, range 0..4095.
REQ-015 Instruction assembly: wr_data[7:0] = low byte, wr_data[8] = high byte bit 0.
REQ-016 States: S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_FLUSH, S_START, S_ERR.
REQ-017 in_ready = 1 in S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI; 0 in S_FLUSH, S_START, S_ERR.
REQ-018 S_LEN_LO: on transfer, latch low count byte, go S_LEN_HI.
REQ-019 S_LEN_HI: on transfer with in_data[7:4] != 0 go S_ERR; else if N == 0 go S_START; else go S_INS_LO.
REQ-020 S_INS_LO: on transfer, latch low byte, go S_INS_HI.
REQ-021 S_INS_HI: on transfer with in_data[7:1] != 0 go S_ERR with no write; else schedule write; go S_FLUSH if this is instruction N, else S_INS_LO.
REQ-022 Write latency: wr_en = 1 for exactly the one cycle following the S_INS_HI transfer, with wr_addr and wr_data valid in that same cycle.
REQ-023 wr_addr of instruction k (0-based) = k; addresses strictly increasing from 0, no gaps.
REQ-024 S_FLUSH lasts one cycle, during which the final wr_en is asserted; it then goes to S_START.
REQ-025 S_START asserts start for one cycle, then goes to S_LEN_LO; a new load may begin immediately.
REQ-026 start never coincides with wr_en; the last write precedes start by exactly one cycle.
REQ-027 busy = 1 from the cycle after the LEN_LO transfer through the cycle start is asserted; otherwise 0.
REQ-028 S_ERR: err = 1, in_ready = 0, wr_en = 0, start = 0; state held until reset.
REQ-029 Back-to-back bytes (in_valid held high) sustain one byte per cycle in all accepting states.
REQ-030 in_valid low stalls the FSM with all latched values held; wr_en is not affected.
REQ-031 in_data is ignored when in_ready = 0.

Reset
REQ-032 While reset is asserted: state = S_LEN_LO, wr_en = 0, wr_addr = 0, wr_data = 0, start = 0, busy = 0, err = 0, and all internal counts = 0.
REQ-033 Reset asserted mid-load aborts the load immediately; no further wr_en or start is asserted; the first byte after reset deasserts is treated as LEN_LO.
REQ-034 in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-035 Stream 03,00,12,00,34,01,FF,00 with in_valid held -> writes (0,0x012),(1,0x134),(2,0x0FF) on consecutive odd cycles; start one cycle after the last write; busy falls after start.
REQ-036 Stream 00,00 -> no wr_en; start pulses on the cycle after the LEN_HI transfer; then in_ready = 1.
REQ-037 Stream 01,00,AA,02 -> err = 1, no wr_en, no start; in_ready stays 0 until reset.
REQ-038 Stream 02,00,11,00 with in_valid toggling 1/0 every cycle, then 22,01 -> writes (0,0x011),(1,0x122); byte order and values are unaffected by stalls.
REQ-039 Reset asserted after 02,00,11 -> outputs return to reset values asynchronously; subsequent 01,00,05,00 -> a single write (0,0x005) followed by start.
REQ-040 Header 00,10 (N = 4096 encoding) -> err = 1 after the LEN_HI transfer, no writes.
